// File: rtl/pa_cal_pkg.sv
// ============================================================================
// Module      : pa_cal_pkg
// Description : Shared types and width helpers for the PA calibration mean path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pa_cal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } pa_mean_st_e;

    // Width of a counter able to hold 0..max_len inclusive.
    function automatic int pa_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Width of a sum of max_len samples, each size_data bits wide.
    function automatic int pa_sum_w(input int size_data, input int max_len);
        return size_data + $clog2(max_len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pa_seq_div.sv
// ============================================================================
// Module      : pa_seq_div
// Description : Restoring shift-subtract divider, one quotient bit per cycle,
//               fixed latency of DIVIDEND_W cycles after i_start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pa_seq_div #(
    parameter int DIVIDEND_W = 35,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic [DIVIDEND_W-1:0] o_quot,
    output logic                  o_done
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] r_quot;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_div;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;

    logic [DIVISOR_W:0]    w_shift;
    logic [DIVISOR_W+1:0]  w_diff;
    logic                  w_borrow;
    logic [DIVISOR_W+1:0]  w_rem_next;

    // The remainder stays below the divisor, so the shifted partial remainder
    // fits DIVISOR_W+1 bits and the extra top bit of w_diff is the borrow.
    assign w_shift    = {r_rem, r_quot[DIVIDEND_W-1]};
    assign w_diff     = {1'b0, w_shift} - {2'b00, r_div};
    assign w_borrow   = w_diff[DIVISOR_W+1];
    assign w_rem_next = w_borrow ? {1'b0, w_shift} : w_diff;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_quot <= i_dividend;
            r_rem  <= '0;
            r_div  <= i_divisor;
            r_cnt  <= CNT_W'(DIVIDEND_W);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_quot <= {r_quot[DIVIDEND_W-2:0], ~w_borrow};
            r_rem  <= DIVISOR_W'(w_rem_next);
            r_cnt  <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_quot = r_quot;
    assign o_done = r_done;

endmodule

`default_nettype wire

// File: rtl/pa_cal_sum_mean.sv
// ============================================================================
// Module      : pa_cal_sum_mean
// Description : Streaming sum of a programmable number of samples followed by
//               a sequential divide for the mean. Define PA_MEAN_ROUND_EN for
//               a round-half-up mean; otherwise the mean is floored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pa_cal_sum_mean
    import pa_cal_pkg::*;
#(
    parameter int SIZE_DATA = 32,
    parameter int MAX_LEN   = 64,
    parameter int LEN_W     = pa_len_w(MAX_LEN),
    parameter int SUM_W     = pa_sum_w(SIZE_DATA, MAX_LEN)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [LEN_W-1:0]     i_len,
    input  logic                 i_valid,
    input  logic [SIZE_DATA-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_busy,
    output logic [SUM_W-1:0]     o_sum,
    output logic [SIZE_DATA-1:0] o_mean,
    output logic                 o_done
);

    pa_mean_st_e r_state;
    pa_mean_st_e w_state_next;

    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_cnt;
    logic [SUM_W-1:0]     r_acc;
    logic [SUM_W-1:0]     r_sum;
    logic [SIZE_DATA-1:0] r_mean;

    logic                 w_start_acc;
    logic [LEN_W-1:0]     w_len_clamp;
    logic                 w_accept;
    logic                 w_last;
    logic [LEN_W-1:0]     w_cnt_next;
    logic [SUM_W-1:0]     w_acc_next;
    logic [SUM_W-1:0]     w_dividend;
    logic                 w_div_start;
    logic [SUM_W-1:0]     w_quot;
    logic                 w_div_done;

    assign w_start_acc = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_len_clamp = (i_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_len;
    assign w_accept    = i_valid && (r_state == ST_ACC);
    assign w_cnt_next  = r_cnt + LEN_W'(1);
    assign w_last      = (w_cnt_next == r_len);
    assign w_acc_next  = r_acc + SUM_W'(i_data);

`ifdef PA_MEAN_ROUND_EN
    // Adding len/2 before the divide rounds half up; headroom in SUM_W covers it.
    assign w_dividend = w_acc_next + SUM_W'(r_len >> 1);
`else
    assign w_dividend = w_acc_next;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_next = (w_len_clamp == '0) ? ST_DONE : ST_ACC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (w_accept && w_last) begin
                    w_state_next = ST_DIV;
                end
            end
            ST_DIV: begin
                if (w_div_done) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready     = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        w_div_start = 1'b0;
        case (r_state)
            ST_ACC: begin
                o_ready     = 1'b1;
                o_busy      = 1'b1;
                w_div_start = w_accept && w_last;
            end
            ST_DIV:  o_busy = 1'b1;
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_len  <= '0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_sum  <= '0;
            r_mean <= '0;
        end else begin
            if (w_start_acc) begin
                r_len <= w_len_clamp;
                r_cnt <= '0;
                r_acc <= '0;
                if (w_len_clamp == '0) begin
                    r_sum  <= '0;
                    r_mean <= '0;
                end
            end else if (w_accept) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
                if (w_last) begin
                    r_sum <= w_acc_next;
                end
            end
            // Quotient is bounded by 2^SIZE_DATA-1, so truncation loses nothing.
            if ((r_state == ST_DIV) && w_div_done) begin
                r_mean <= SIZE_DATA'(w_quot);
            end
        end
    end

    pa_seq_div #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (LEN_W)
    ) u_div (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (w_div_start),
        .i_dividend (w_dividend),
        .i_divisor  (r_len),
        .o_quot     (w_quot),
        .o_done     (w_div_done)
    );

    assign o_sum  = r_sum;
    assign o_mean = r_mean;

endmodule

`default_nettype wire

// File: tb/tb_pa_cal_sum_mean.sv
// ============================================================================
// Module      : tb_pa_cal_sum_mean
// Description : Directed-vector bench for pa_cal_sum_mean (SIZE_DATA=32, MAX_LEN=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pa_cal_sum_mean;

    localparam int SIZE_DATA = 32;
    localparam int MAX_LEN   = 8;
    localparam int LEN_W     = 4;
    localparam int SUM_W     = 35;
    localparam int LAT       = SUM_W + 1;
`ifdef PA_MEAN_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_start;
    logic [LEN_W-1:0]     i_len;
    logic                 i_valid;
    logic [SIZE_DATA-1:0] i_data;
    logic                 o_ready;
    logic                 o_busy;
    logic [SUM_W-1:0]     o_sum;
    logic [SIZE_DATA-1:0] o_mean;
    logic                 o_done;

    pa_cal_sum_mean #(
        .SIZE_DATA (SIZE_DATA),
        .MAX_LEN   (MAX_LEN)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (i_start),
        .i_len   (i_len),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_busy  (o_busy),
        .o_sum   (o_sum),
        .o_mean  (o_mean),
        .o_done  (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LEN_W-1:0]          len;
        int                        nsamp;
        logic [7:0][SIZE_DATA-1:0] data;
        logic [SUM_W-1:0]          sum;
        logic [SIZE_DATA-1:0]      mfloor;
        logic [SIZE_DATA-1:0]      mround;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int len, input int n,
                                input logic [31:0] d0, d1, d2, d3, d4, d5, d6, d7,
                                input logic [34:0] s, input logic [31:0] mf, mr);
        vec_t v;
        v.len   = LEN_W'(len);
        v.nsamp = n;
        v.data  = {d7, d6, d5, d4, d3, d2, d1, d0};
        v.sum   = s;
        v.mfloor = mf;
        v.mround = mr;
        return v;
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (o_done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Starts a run at the current cycle, feeds samples back-to-back, checks results.
    task automatic do_run(input vec_t v, input string tag);
        int cyc;
        i_start = 1'b1;
        i_len   = v.len;
        @(posedge clk); #1;
        i_start = 1'b0;
        check({tag, "_ready"}, 64'(o_ready), 64'd1);
        for (int k = 0; k < v.nsamp; k++) begin
            i_valid = 1'b1;
            i_data  = v.data[k];
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_data  = '0;
        wait_done(cyc);
        check({tag, "_latency"}, 64'(cyc), 64'(LAT));
        check({tag, "_sum"}, 64'(o_sum), 64'(v.sum));
        check({tag, "_mean"}, 64'(o_mean), 64'(ROUND ? v.mround : v.mfloor));
    endtask

    vec_t vecs [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [6:0]  gap_valid;
        logic [31:0] gap_data [7];

        vecs[0] = mk(4, 4, 10, 20, 30, 41, 0, 0, 0, 0, 35'd101, 32'd25, 32'd25);
        vecs[1] = mk(3, 3, 1, 2, 2, 0, 0, 0, 0, 0, 35'd5, 32'd1, 32'd2);
        vecs[2] = mk(8, 8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     35'h7FFFFFFF8, 32'hFFFFFFFF, 32'hFFFFFFFF);
        vecs[3] = mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 35'd7, 32'd7, 32'd7);
        vecs[4] = mk(5, 5, 100, 0, 0, 0, 3, 0, 0, 0, 35'd103, 32'd20, 32'd21);
        vecs[5] = mk(15, 8, 1, 2, 3, 4, 5, 6, 7, 8, 35'd36, 32'd4, 32'd5);
        vecs[6] = mk(2, 2, 3, 4, 0, 0, 0, 0, 0, 0, 35'd7, 32'd3, 32'd4);

        rst = 1'b1; i_start = 1'b0; i_len = '0; i_valid = 1'b0; i_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sum",   64'(o_sum),   64'd0);
        check("rst_mean",  64'(o_mean),  64'd0);
        check("rst_done",  64'(o_done),  64'd0);
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_busy",  64'(o_busy),  64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Each run after the first starts in the DONE cycle of the previous one.
        for (int i = 0; i < 7; i++) begin
            do_run(vecs[i], $sformatf("v%0d", i));
        end

        // Gapped valid, ignored start during ACC, extra valids after the last sample.
        gap_valid = 7'b1011001;
        gap_data  = '{32'd5, 32'd99, 32'd99, 32'd6, 32'd7, 32'd99, 32'd8};
        i_start = 1'b1; i_len = 4'd4;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            i_valid = gap_valid[k];
            i_data  = gap_data[k];
            i_start = (k == 2);
            i_len   = (k == 2) ? 4'd1 : 4'd4;
            @(posedge clk); #1;
        end
        i_start = 1'b0;
        check("gap_ready_low", 64'(o_ready), 64'd0);
        check("gap_busy",      64'(o_busy),  64'd1);
        i_valid = 1'b1; i_data = 32'd1000;
        repeat (3) @(posedge clk);
        #1;
        i_valid = 1'b0; i_data = '0;
        wait_done(cyc);
        check("gap_latency", 64'(cyc + 3), 64'(LAT));
        check("gap_sum",     64'(o_sum),   64'd26);
        check("gap_mean",    64'(o_mean),  64'(ROUND ? 32'd7 : 32'd6));

        // Zero length: done the cycle after the start, results cleared.
        i_start = 1'b1; i_len = 4'd0;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("len0_done", 64'(o_done), 64'd1);
        check("len0_sum",  64'(o_sum),  64'd0);
        check("len0_mean", 64'(o_mean), 64'd0);
        check("len0_busy", 64'(o_busy), 64'd0);
        @(posedge clk); #1;
        check("len0_done_pulse", 64'(o_done), 64'd0);

        // Asynchronous reset in the middle of the divide.
        i_start = 1'b1; i_len = 4'd4;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_valid = 1'b1;
            i_data  = vecs[0].data[k];
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_data = '0;
        repeat (10) @(posedge clk);
        #2;
        check("div_sum_early", 64'(o_sum),  64'd101);
        check("div_busy",      64'(o_busy), 64'd1);
        rst = 1'b1;
        #1;
        check("arst_sum",   64'(o_sum),   64'd0);
        check("arst_mean",  64'(o_mean),  64'd0);
        check("arst_busy",  64'(o_busy),  64'd0);
        check("arst_ready", 64'(o_ready), 64'd0);
        check("arst_done",  64'(o_done),  64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_run(vecs[0], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
